muldiv_unit: RTL and testbench

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_unit.sv | 142 ++++++++++++++
 tb/tb_muldiv_unit.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative multiply/divide unit with architectural HI/LO registers
// Signed ops work on magnitudes; result signs are fixed up when FIN is entered.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, MUL, DIV, FIN} state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic               sa_q, sa_d, sb_q, sb_d, bz_q, bz_d;
    logic               done_q, done_d, dz_q, dz_d;
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;

    logic               is_signed;
    logic [WIDTH-1:0]   a_mag, b_mag, addend, quo, rem;
    logic [WIDTH:0]     add_sum, sub_diff;
    logic [2*WIDTH-1:0] prod;

    // acc holds {partial product, multiplier} for MUL and {remainder, quotient} for DIV
    always_comb begin
        is_signed = ~op[0];
        a_mag     = (is_signed && a[WIDTH-1]) ? -a : a;
        b_mag     = (is_signed && b[WIDTH-1]) ? -b : b;
        addend    = acc_q[0] ? opnd_q : {WIDTH{1'b0}};
        add_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, addend};
        sub_diff  = acc_q[2*WIDTH-1:WIDTH-1] - {1'b0, opnd_q};
        prod      = (sa_q ^ sb_q) ? -acc_q : acc_q;
        quo       = (sa_q ^ sb_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        rem       = sa_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        opnd_d  = opnd_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        bz_d    = bz_q;
        done_d  = 1'b0;
        dz_d    = 1'b0;
        hi_d    = hi_we ? wdata : hi_q;
        lo_d    = lo_we ? wdata : lo_q;
        if (flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        sa_d    = is_signed & a[WIDTH-1];
                        sb_d    = is_signed & b[WIDTH-1];
                        bz_d    = (b == {WIDTH{1'b0}});
                        cnt_d   = CW'(WIDTH);
                        state_d = op[1] ? DIV : MUL;
                        acc_d   = {{WIDTH{1'b0}}, op[1] ? a_mag : b_mag};
                        opnd_d  = op[1] ? b_mag : a_mag;
                    end
                end
                MUL: begin
                    if (cnt_q != '0) begin
                        acc_d = {add_sum, acc_q[WIDTH-1:1]};
                        cnt_d = cnt_q - CW'(1);
                    end else begin
                        state_d      = FIN;
                        done_d       = 1'b1;
                        {hi_d, lo_d} = prod;
                    end
                end
                DIV: begin
                    if (cnt_q != '0) begin
                        acc_d = sub_diff[WIDTH] ? {acc_q[2*WIDTH-2:0], 1'b0}
                                                : {sub_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
                        cnt_d = cnt_q - CW'(1);
                    end else begin
                        state_d = FIN;
                        done_d  = 1'b1;
                        dz_d    = bz_q;
                        if (!bz_q) begin
                            lo_d = quo;
                            hi_d = rem;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            opnd_q  <= '0;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            bz_q    <= 1'b0;
            done_q  <= 1'b0;
            dz_q    <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            opnd_q  <= opnd_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            bz_q    <= bz_d;
            done_q  <= done_d;
            dz_q    <= dz_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign busy     = (state_q == MUL) || (state_q == DIV) || ((state_q == IDLE) && start);
    assign done     = done_q;
    assign div_zero = dz_q;
    assign hi       = hi_q;
    assign lo       = lo_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - randomized self-checking bench for muldiv_unit
module tb_muldiv_unit;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         resetn, start, flush, hi_we, lo_we;
    logic [1:0]   op;
    logic [W-1:0] a, b, wdata;
    logic         busy, done, div_zero;
    logic [W-1:0] hi, lo;

    int           n_checks = 0;
    int           n_pass = 0;
    logic [W-1:0] exp_hi = '0;
    logic [W-1:0] exp_lo = '0;
    logic         exp_dz = 1'b0;

    always #5 clk = ~clk;

    muldiv_unit #(.WIDTH(W)) dut (
        .clk(clk), .resetn(resetn), .start(start), .op(op), .a(a), .b(b),
        .flush(flush), .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
        .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] expv);
        n_checks++;
        if (got === expv) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, expv);
    endtask

    // Reference: plain 64-bit arithmetic; C-style truncating division gives remainder sign of dividend
    function automatic void model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        logic signed [63:0] sp;
        logic [63:0]        up;
        longint             sx, sy, q, r;
        exp_dz = 1'b0;
        case (o)
            2'b00: begin
                sp = $signed({{32{x[31]}}, x}) * $signed({{32{y[31]}}, y});
                {exp_hi, exp_lo} = sp;
            end
            2'b01: begin
                up = {32'd0, x} * {32'd0, y};
                {exp_hi, exp_lo} = up;
            end
            default: begin
                if (y == 0) begin
                    exp_dz = 1'b1;
                end else if (o == 2'b10) begin
                    sx = $signed(x);
                    sy = $signed(y);
                    q = sx / sy;
                    r = sx % sy;
                    exp_lo = q[31:0];
                    exp_hi = r[31:0];
                end else begin
                    exp_lo = x / y;
                    exp_hi = x % y;
                end
            end
        endcase
    endfunction

    task automatic run_op(input string tag, input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        int k;
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        #1 check({tag, "_busy_issue"}, busy, 1);
        @(posedge clk);
        #1;
        start = 1'b0; a = $urandom; b = $urandom; op = 2'($urandom);
        model(o, x, y);
        k = 0;
        @(negedge clk);
        check({tag, "_busy_run"}, busy, 1);
        while (!done && k < 100) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_latency"}, k, W + 1);
        check({tag, "_hi"}, hi, exp_hi);
        check({tag, "_lo"}, lo, exp_lo);
        check({tag, "_dz"}, div_zero, exp_dz);
        check({tag, "_busy_fin"}, busy, 0);
    endtask

    initial begin
        int dcount;
        logic [1:0]   ro;
        logic [W-1:0] rx, ry;
        resetn = 1'b1; start = 1'b0; flush = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
        op = 2'b00; a = '0; b = '0; wdata = '0;
        #2 resetn = 1'b0;
        #1;
        check("rst_hi", hi, 0);
        check("rst_lo", lo, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_dz", div_zero, 0);
        @(negedge clk);
        resetn = 1'b1;

        run_op("mult_neg", 2'b00, 32'hFFFFFFFD, 32'd5);
        check("mult_neg_hi_const", hi, 32'hFFFFFFFF);
        check("mult_neg_lo_const", lo, 32'hFFFFFFF1);
        run_op("divu", 2'b11, 32'd100, 32'd7);
        check("divu_lo_const", lo, 32'd14);
        check("divu_hi_const", hi, 32'd2);
        run_op("div_neg", 2'b10, 32'hFFFFFFF9, 32'd2);
        check("div_neg_lo_const", lo, 32'hFFFFFFFD);
        check("div_neg_hi_const", hi, 32'hFFFFFFFF);
        run_op("mult_min", 2'b00, 32'h80000000, 32'h80000000);
        check("mult_min_hi_const", hi, 32'h40000000);

        // MTHI / MTLO preload, then divide by zero must leave them intact
        @(negedge clk); hi_we = 1'b1; wdata = 32'h11;
        @(negedge clk); hi_we = 1'b0; lo_we = 1'b1; wdata = 32'h22;
        @(negedge clk); lo_we = 1'b0;
        exp_hi = 32'h11; exp_lo = 32'h22;
        check("mt_hi", hi, exp_hi);
        check("mt_lo", lo, exp_lo);
        run_op("div0", 2'b10, 32'd1234, 32'd0);
        check("div0_hi_const", hi, 32'h11);

        // Flush mid-operation
        @(negedge clk); start = 1'b1; op = 2'b01; a = 32'hFFFFFFFF; b = 32'hFFFFFFFF;
        @(posedge clk); #1 start = 1'b0;
        repeat (10) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_busy", busy, 0);
        dcount = 0;
        repeat (50) begin
            @(negedge clk);
            if (done) dcount++;
        end
        check("flush_nodone", dcount, 0);
        check("flush_hi", hi, exp_hi);
        check("flush_lo", lo, exp_lo);
        run_op("after_flush", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF);

        // MTLO colliding with FIN entry: the product wins
        @(negedge clk); start = 1'b1; op = 2'b01; a = 32'd3; b = 32'd4;
        @(posedge clk); #1 start = 1'b0;
        repeat (W + 1) @(negedge clk);
        lo_we = 1'b1; wdata = 32'h5;
        @(negedge clk);
        lo_we = 1'b0;
        exp_hi = 32'd0; exp_lo = 32'd12;
        check("collide_done", done, 1);
        check("collide_lo", lo, exp_lo);
        check("collide_hi", hi, exp_hi);

        // Reset pulse mid-divide
        @(negedge clk); start = 1'b1; op = 2'b11; a = 32'd999; b = 32'd10;
        @(posedge clk); #1 start = 1'b0;
        repeat (20) @(negedge clk);
        resetn = 1'b0;
        #1;
        exp_hi = '0; exp_lo = '0;
        check("midrst_hi", hi, 0);
        check("midrst_lo", lo, 0);
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        @(negedge clk);
        resetn = 1'b1;
        run_op("after_rst", 2'b11, 32'd999, 32'd10);

        for (int i = 0; i < 40; i++) begin
            ro = 2'($urandom_range(0, 3));
            rx = $urandom;
            ry = $urandom >> $urandom_range(0, 31);
            if ($urandom_range(0, 7) == 0) ry = '0;
            if ($urandom_range(0, 7) == 0) rx = 32'h80000000;
            if ($urandom_range(0, 7) == 0) ry = 32'hFFFFFFFF;
            run_op($sformatf("rnd%0d_op%0d", i, ro), ro, rx, ry);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
